// File: rtl/led_pattern_engine.sv
// led_pattern_engine: rotating / bouncing LED pattern driven by control_decoder.
// Steps come from a speed-selectable prescaler on clk_div.
module led_pattern_engine #(
    parameter int               WIDTH    = 16,
    parameter int               SLOW_DIV = 8,
    parameter int               FAST_DIV = 2,
    parameter logic [WIDTH-1:0] SEED     = WIDTH'(1)
) (
    input  logic             clk_div,
    input  logic             BTN0,
    input  logic [3:0]       ctrl_nibble,
    output logic [WIDTH-1:0] led,
    output logic             step_pulse,
    output logic [7:0]       step_cnt
);

    localparam int PW = $clog2(SLOW_DIV);
    localparam logic [PW-1:0] SLOW_M1 = PW'(SLOW_DIV - 1);
    localparam logic [PW-1:0] FAST_M1 = PW'(FAST_DIV - 1);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [3:0]       ctrl_q;
    logic             mode_d;
    logic             bounce_dir;
    logic [PW-1:0]    presc;

    logic [PW-1:0]    div_m1;
    logic             step;
    logic             mode_rise;
    logic             cur_dir;
    logic             bdir_nxt;
    logic [WIDTH-1:0] led_nxt;

    // Register the control nibble and remember the previous mode bit
    always_ff @(posedge clk_div or negedge BTN0) begin
        if (!BTN0) begin
            ctrl_q <= '0;
            mode_d <= 1'b0;
        end else begin
            ctrl_q <= ctrl_nibble;
            mode_d <= ctrl_q[2];
        end
    end

    // Step decision and next pattern / bounce direction
    always_comb begin
        div_m1    = ctrl_q[3] ? FAST_M1 : SLOW_M1;
        step      = (state == RUN) && ctrl_q[0] && (presc >= div_m1);
        mode_rise = ctrl_q[2] && !mode_d;
        cur_dir   = mode_rise ? ctrl_q[1] : bounce_dir;
        bdir_nxt  = cur_dir;
        led_nxt   = led;
        if (led == '0) begin
            led_nxt = SEED;
        end else if (!ctrl_q[2]) begin
            if (ctrl_q[1])
                led_nxt = {led[0], led[WIDTH-1:1]};
            else
                led_nxt = {led[WIDTH-2:0], led[WIDTH-1]};
        end else if (!cur_dir) begin
            if (led[WIDTH-1]) begin
                bdir_nxt = 1'b1;
                led_nxt  = {1'b0, led[WIDTH-1:1]};
            end else begin
                led_nxt  = {led[WIDTH-2:0], 1'b0};
            end
        end else begin
            if (led[0]) begin
                bdir_nxt = 1'b0;
                led_nxt  = {led[WIDTH-2:0], 1'b0};
            end else begin
                led_nxt  = {1'b0, led[WIDTH-1:1]};
            end
        end
    end

    // Run/idle FSM and prescaler; entry edge counts as the first tick
    always_ff @(posedge clk_div or negedge BTN0) begin
        if (!BTN0) begin
            state <= IDLE;
            presc <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    presc <= ctrl_q[0] ? PW'(1) : '0;
                    state <= ctrl_q[0] ? RUN : IDLE;
                end
                RUN: begin
                    if (!ctrl_q[0]) begin
                        presc <= '0;
                        state <= IDLE;
                    end else if (step) begin
                        presc <= '0;
                    end else begin
                        presc <= presc + PW'(1);
                    end
                end
                default: begin
                    presc <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Pattern, bounce direction, step counter and strobe
    always_ff @(posedge clk_div or negedge BTN0) begin
        if (!BTN0) begin
            led        <= SEED;
            bounce_dir <= 1'b0;
            step_cnt   <= '0;
            step_pulse <= 1'b0;
        end else begin
            step_pulse <= step;
            if (step) begin
                led        <= led_nxt;
                step_cnt   <= step_cnt + 8'd1;
                bounce_dir <= ctrl_q[2] ? bdir_nxt : cur_dir;
            end else begin
                bounce_dir <= cur_dir;
            end
        end
    end

endmodule

// File: tb/tb_led_pattern_engine.sv
// tb_led_pattern_engine: directed scenarios plus random control traffic,
// checked every cycle against an arithmetic model of the pattern rules.
module tb_led_pattern_engine;

    logic        clk_div = 1'b0;
    logic        BTN0 = 1'b1;
    logic [3:0]  ctrl_nibble = 4'h0;
    logic [15:0] led;
    logic        step_pulse;
    logic [7:0]  step_cnt;

    int vectors = 0;
    int errors  = 0;
    bit chk_en  = 0;

    led_pattern_engine dut (
        .clk_div    (clk_div),
        .BTN0       (BTN0),
        .ctrl_nibble(ctrl_nibble),
        .led        (led),
        .step_pulse (step_pulse),
        .step_cnt   (step_cnt)
    );

    initial forever #5 clk_div = ~clk_div;

    // Model state
    logic [3:0]  m_ctrl;
    logic        m_prev_mode;
    logic        m_bdir;
    int          m_elapsed;
    logic [15:0] m_led;
    int          m_cnt;
    logic        m_pulse;

    typedef struct packed {
        logic [15:0] led;
        logic        bdir;
        logic        stp;
    } nxt_t;

    function automatic nxt_t model_next(logic [3:0] c, logic pm, logic bd,
                                        int el, logic [15:0] l);
        nxt_t r;
        int v;
        int dv;
        logic d;
        v  = int'(l);
        dv = c[3] ? 2 : 8;
        r.stp = c[0] && (el >= dv - 1);
        d = (c[2] && !pm) ? c[1] : bd;
        if (r.stp) begin
            if (v == 0)
                v = 1;
            else if (!c[2])
                v = c[1] ? (v / 2 + (v % 2) * 32768) : ((v * 2) % 65536 + v / 32768);
            else if (!d) begin
                if (v >= 32768) begin d = 1'b1; v = v / 2; end
                else v = (v * 2) % 65536;
            end else begin
                if (v % 2 == 1) begin d = 1'b0; v = (v * 2) % 65536; end
                else v = v / 2;
            end
        end
        r.led  = v[15:0];
        r.bdir = d;
        return r;
    endfunction

    nxt_t m_nx;
    assign m_nx = model_next(m_ctrl, m_prev_mode, m_bdir, m_elapsed, m_led);

    always @(posedge clk_div or negedge BTN0) begin
        if (!BTN0) begin
            m_ctrl <= 4'h0; m_prev_mode <= 1'b0; m_bdir <= 1'b0;
            m_elapsed <= 0; m_led <= 16'h0001; m_cnt <= 0; m_pulse <= 1'b0;
        end else begin
            m_ctrl      <= ctrl_nibble;
            m_prev_mode <= m_ctrl[2];
            m_bdir      <= m_nx.bdir;
            m_led       <= m_nx.led;
            m_pulse     <= m_nx.stp;
            m_cnt       <= m_nx.stp ? (m_cnt + 1) % 256 : m_cnt;
            m_elapsed   <= (!m_ctrl[0] || m_nx.stp) ? 0 : m_elapsed + 1;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Every-cycle comparison against the model
    always @(negedge clk_div) begin
        if (chk_en && BTN0) begin
            chk("led", 32'(led), 32'(m_led));
            chk("step_cnt", 32'(step_cnt), 32'(m_cnt));
            chk("step_pulse", 32'(step_pulse), 32'(m_pulse));
        end
    end

    task automatic async_reset();
        @(negedge clk_div);
        #2 BTN0 = 1'b0;
        ctrl_nibble = 4'h0;
        #1;
        chk("rst_led", 32'(led), 32'h0001);
        chk("rst_cnt", 32'(step_cnt), 32'h0);
        chk("rst_pulse", 32'(step_pulse), 32'h0);
        @(negedge clk_div);
        BTN0 = 1'b1;
    endtask

    initial begin
        int pulses;
        logic [15:0] snap_led;
        int snap_cnt;

        // Fast rotate left from SEED
        async_reset();
        chk_en = 1;
        ctrl_nibble = 4'b1001;
        pulses = 0;
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk_div);
            pulses += int'(step_pulse);
            if (k == 2) chk("fast_first_hold", 32'(led), 32'h0001);
            if (k == 3) chk("fast_first_step", 32'(led), 32'h0002);
            if (k == 5) chk("fast_second", 32'(led), 32'h0004);
        end
        chk("fast16_led", 32'(led), 32'h0001);
        chk("fast16_cnt", 32'(step_cnt), 32'd16);
        chk("fast16_pulses", 32'(pulses), 32'd16);

        // Slow rotate right
        async_reset();
        ctrl_nibble = 4'b0011;
        for (int k = 1; k <= 17; k++) begin
            @(negedge clk_div);
            if (k == 8)  chk("slow_hold", 32'(led), 32'h0001);
            if (k == 9)  chk("slow_first", 32'(led), 32'h8000);
            if (k == 17) chk("slow_second", 32'(led), 32'h4000);
        end

        // Fast bounce from SEED
        async_reset();
        ctrl_nibble = 4'b1101;
        for (int k = 1; k <= 63; k++) begin
            @(negedge clk_div);
            if (k == 31) chk("bounce15", 32'(led), 32'h8000);
            if (k == 33) chk("bounce16", 32'(led), 32'h4000);
            if (k == 61) chk("bounce30", 32'(led), 32'h0001);
            if (k == 63) chk("bounce31", 32'(led), 32'h0002);
        end

        // Slow run, switch to fast with prescaler at 5
        async_reset();
        ctrl_nibble = 4'b0001;
        repeat (5) @(negedge clk_div);
        ctrl_nibble = 4'b1001;
        @(negedge clk_div);
        chk("spd_hold", 32'(led), 32'h0001);
        @(negedge clk_div);
        chk("spd_step", 32'(led), 32'h0002);
        repeat (2) @(negedge clk_div);
        chk("spd_next", 32'(led), 32'h0004);

        // Drop run for 20 cycles, then resume
        ctrl_nibble = 4'b1000;
        repeat (2) @(negedge clk_div);
        snap_led = m_led;
        snap_cnt = m_cnt;
        repeat (20) @(negedge clk_div);
        chk("frozen_led", 32'(led), 32'(snap_led));
        chk("frozen_cnt", 32'(step_cnt), 32'(snap_cnt));
        ctrl_nibble = 4'b1001;
        repeat (2) @(negedge clk_div);
        chk("resume_hold", 32'(led), 32'(snap_led));
        @(negedge clk_div);
        chk("resume_step", 32'(led), 32'({snap_led[14:0], snap_led[15]}));

        // Reset mid-run between edges, then wrap the step counter
        repeat (7) @(negedge clk_div);
        async_reset();
        ctrl_nibble = 4'b1001;
        for (int k = 1; k <= 513; k++) begin
            @(negedge clk_div);
            if (k == 511) chk("cnt255", 32'(step_cnt), 32'd255);
        end
        chk("wrap_cnt", 32'(step_cnt), 32'd0);
        chk("wrap_led", 32'(led), 32'h0001);

        // Random control traffic
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk_div);
            if ($urandom_range(7) == 0)
                ctrl_nibble = 4'($urandom_range(15)) | 4'($urandom_range(3) != 0);
            if ($urandom_range(499) == 0)
                async_reset();
        end

        @(negedge clk_div);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
